// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-ported memory with starvation guard and bus timeout
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_next;
    logic          owner;
    logic          err;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          grant_d, grant_if;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        bus_err    = 1'b0;
        case (state)
            IDLE: begin
                // Data wins ties until it has taken MAX_D_STREAK grants in a row over a waiting fetch.
                if (d_req && !(if_req && streak == STREAK_MAX)) begin
                    grant_d    = 1'b1;
                    state_next = BUSY;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready || tcnt == TCNT_LAST) state_next = DONE;
            end
            DONE: begin
                if_ack     = !owner;
                d_ack      = owner;
                bus_err    = err;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= 1'b0;
            err       <= 1'b0;
            streak    <= '0;
            tcnt      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant_d || grant_if) begin
                owner     <= grant_d;
                mem_req   <= 1'b1;
                mem_we    <= grant_d & d_we;
                mem_addr  <= grant_d ? d_addr : if_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
                if (grant_d && if_req)
                    streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
                else
                    streak <= '0;
            end
            if (state == BUSY) begin
                tcnt <= tcnt + 1'b1;
                if (mem_ready) begin
                    mem_req <= 1'b0;
                    if (owner) d_rdata  <= mem_we ? '0 : mem_rdata;
                    else       if_rdata <= mem_rdata;
                end else if (tcnt == TCNT_LAST) begin
                    mem_req <= 1'b0;
                    err     <= 1'b1;
                    if (owner) d_rdata  <= '0;
                    else       if_rdata <= '0;
                end
            end
            if (state == DONE) begin
                tcnt <= '0;
                err  <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

    // The granted requester must hold its request until it sees the ack.
    always_ff @(posedge clk) begin
        if (!reset && state == BUSY) assert (owner ? d_req : if_req);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a cycle reference model
module tb_mem_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_ack, d_ack, bus_err, mem_req, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: ready arrives in the resp_lat-th cycle of mem_req (0 = never).
    int          resp_lat  = 1;
    int          resp_age  = 0;
    bit          resp_rand = 1'b0;
    logic [31:0] resp_data = '0;

    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            resp_age++;
            if (resp_rand && resp_age == 1) resp_lat = $urandom_range(1, 5);
            mem_ready = (resp_lat != 0) && (resp_age == resp_lat);
            mem_rdata = (mem_ready && !resp_rand) ? resp_data : $urandom;
        end else begin
            resp_age  = 0;
            mem_ready = resp_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            mem_rdata = $urandom;
        end
    end

    // Reference model: one access at a time, described by how many busy cycles it has used.
    bit          cmp_en = 1'b0;
    bit          m_active = 1'b0, m_done = 1'b0, m_owner = 1'b0, m_we = 1'b0, m_err = 1'b0;
    bit          m_d_wins;
    int          m_used = 0, m_streak = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ird = '0, m_drd = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_done = 0; m_owner = 0; m_we = 0; m_err = 0;
            m_used = 0; m_streak = 0; m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
        end else if (m_done) begin
            m_done = 0;
            m_err  = 0;
        end else if (m_active) begin
            m_used++;
            if (mem_ready) begin
                m_active = 0; m_done = 1; m_err = 0;
                if (m_owner) m_drd = m_we ? 32'h0 : mem_rdata;
                else         m_ird = mem_rdata;
            end else if (m_used == TMO) begin
                m_active = 0; m_done = 1; m_err = 1;
                if (m_owner) m_drd = 32'h0;
                else         m_ird = 32'h0;
            end
        end else if (if_req || d_req) begin
            m_d_wins = d_req && !(if_req && m_streak >= MAXS);
            m_active = 1;
            m_used   = 0;
            m_owner  = m_d_wins;
            m_we     = m_d_wins && d_we;
            m_addr   = m_d_wins ? d_addr : if_addr;
            m_wdata  = d_wdata;
            if (m_d_wins && if_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            else                    m_streak = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mem_req", mem_req, m_active);
            if (m_active) begin
                check("mem_we", mem_we, m_we);
                check("mem_addr", mem_addr, m_addr);
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
            end
            check("if_ack", if_ack, m_done && !m_owner);
            check("d_ack", d_ack, m_done && m_owner);
            check("bus_err", bus_err, m_done && m_err);
            check("if_rdata", if_rdata, m_ird);
            check("d_rdata", d_rdata, m_drd);
            check("busy", busy, m_active || m_done);
        end
    end

    // Directed observation of one access: bus values at first mem_req cycle, length, and the ack cycle.
    int          o_hi;
    logic        o_we, o_ia, o_da, o_be;
    logic [31:0] o_addr, o_wd, o_ird, o_drd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        check("wait mem_req", mem_req, 1);
        o_we = mem_we; o_addr = mem_addr; o_wd = mem_wdata;
        o_hi = 0;
        while (mem_req && o_hi < 300) begin
            o_hi++;
            @(negedge clk);
        end
        o_ia = if_ack; o_da = d_ack; o_be = bus_err; o_ird = if_rdata; o_drd = d_rdata;
    endtask

    logic ia_s, da_s;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset mem_req", mem_req, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset mem_we", mem_we, 0);
        check("reset rdata", if_rdata | d_rdata, 0);
        check("reset acks", {bus_err, if_ack, d_ack, busy}, 0);
        tick();
        reset = 1'b0;

        // Fetch only, ready in the second busy cycle.
        resp_lat = 2; resp_data = 32'hDEADBEEF;
        if_addr = 32'h10; if_req = 1'b1;
        observe();
        check("if only len", o_hi, 2);
        check("if only we", o_we, 0);
        check("if only addr", o_addr, 32'h10);
        check("if only ack", {o_ia, o_da, o_be}, 3'b100);
        check("if only rdata", o_ird, 32'hDEADBEEF);
        tick();
        if_req = 1'b0;

        // Collision: data load first, fetch in the following idle.
        resp_lat = 1; resp_data = 32'hCAFEF00D;
        d_we = 1'b0; d_addr = 32'h40; if_addr = 32'h20;
        d_req = 1'b1; if_req = 1'b1;
        observe();
        check("coll first addr", o_addr, 32'h40);
        check("coll first ack", {o_ia, o_da}, 2'b01);
        check("coll d_rdata", o_drd, 32'hCAFEF00D);
        tick();
        d_req = 1'b0; resp_data = 32'h0BADF00D;
        observe();
        check("coll second addr", o_addr, 32'h20);
        check("coll second ack", {o_ia, o_da}, 2'b10);
        check("coll if_rdata", o_ird, 32'h0BADF00D);
        tick();
        if_req = 1'b0;

        // Starvation guard: both held, data re-requests after every ack.
        if_addr = 32'h100; d_addr = 32'h200; if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            observe();
            check($sformatf("grant order %0d", k), o_da, (k == 4) ? 1'b0 : 1'b1);
            tick();
            if (k == 5) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end

        // Store.
        d_we = 1'b1; d_wdata = 32'h12345678; d_addr = 32'h80; d_req = 1'b1;
        observe();
        check("store we", o_we, 1);
        check("store addr", o_addr, 32'h80);
        check("store wdata", o_wd, 32'h12345678);
        check("store ack", {o_da, o_be}, 2'b10);
        check("store d_rdata", o_drd, 0);
        tick();
        d_req = 1'b0; d_we = 1'b0;

        // Ready on the last allowed cycle: no error.
        resp_lat = TMO; resp_data = 32'h5A5A5A5A;
        d_addr = 32'h44; d_req = 1'b1;
        observe();
        check("late ready len", o_hi, TMO);
        check("late ready ack", {o_da, o_be}, 2'b10);
        check("late ready rdata", o_drd, 32'h5A5A5A5A);
        tick();
        d_req = 1'b0;

        // Timeout.
        resp_lat = 0;
        d_req = 1'b1;
        observe();
        check("timeout len", o_hi, TMO);
        check("timeout ack", {o_da, o_be}, 2'b11);
        check("timeout rdata", o_drd, 0);
        tick();
        d_req = 1'b0;

        // Reset in the middle of an access.
        d_addr = 32'h48; d_req = 1'b1;
        observe_start: begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!mem_req && n < 20);
            check("rst wait mem_req", mem_req, 1);
        end
        repeat (3) @(negedge clk);
        tick();
        reset = 1'b1; d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst mem_req", mem_req, 0);
        check("rst busy", busy, 0);
        check("rst no ack", {if_ack, d_ack, bus_err}, 0);
        tick();
        reset = 1'b0;
        resp_lat = 1; resp_data = 32'h77778888;
        d_addr = 32'h4C; d_req = 1'b1;
        observe();
        check("post rst ack", {o_da, o_be}, 2'b10);
        check("post rst rdata", o_drd, 32'h77778888);
        tick();
        d_req = 1'b0;

        // Randomized traffic against the model.
        resp_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ia_s = if_ack;
            da_s = d_ack;
            tick();
            if (if_req) begin
                if (ia_s) begin
                    if ($urandom_range(0, 1) == 1) if_addr = $urandom;
                    else                           if_req  = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (d_req) begin
                if (da_s) begin
                    if ($urandom_range(0, 1) == 1) begin
                        d_addr = $urandom; d_we = $urandom_range(0, 1); d_wdata = $urandom;
                    end else d_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_we = $urandom_range(0, 1); d_wdata = $urandom;
            end
        end
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
